// File: rtl/store_unit_pkg.sv
// Shared types for the sub-word store path: store sizes, FSM states, lane widths.
// Also holds the size-normalisation and misalignment helper functions.
package store_unit_pkg;

    localparam int XLEN   = 32;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        SZ_SB = 2'd0,
        SZ_SH = 2'd1,
        SZ_SW = 2'd2
    } store_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_ERR   = 2'd3
    } store_state_e;

    // funct3[1:0] == 3 has no store encoding of its own and is handled as a word store.
    function automatic store_size_e norm_size(input logic [1:0] raw);
        store_size_e sz;
        case (raw)
            2'd0:    sz = SZ_SB;
            2'd1:    sz = SZ_SH;
            default: sz = SZ_SW;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input store_size_e sz, input logic [1:0] lo);
        logic mis;
        case (sz)
            SZ_SB:   mis = 1'b0;
            SZ_SH:   mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Datapath store request plus data-memory write port, bundled for store_unit.
// slave = store_unit side; master = core/memory side.
interface store_unit_if;
    import store_unit_pkg::*;

    logic            req;
    logic [1:0]      size;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic            done;
    logic            err;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [XLEN-1:0] mem_wd;
    logic [XLEN-1:0] mem_rd;

    modport master (
        output req, size, addr, wdata, mem_rd,
        input  busy, done, err, mem_addr, mem_we, mem_wd
    );

    modport slave (
        input  req, size, addr, wdata, mem_rd,
        output busy, done, err, mem_addr, mem_we, mem_wd
    );

endinterface

// File: rtl/store_unit_merge.sv
// store_merge: combinational little-endian lane merge of store data into the
// word previously read from memory.
module store_merge
    import store_unit_pkg::*;
(
    input  logic [XLEN-1:0] i_rd_q,
    input  logic [XLEN-1:0] i_wdata_q,
    input  store_size_e     i_size_q,
    input  logic [1:0]      i_addr_q,
    output logic [XLEN-1:0] o_mem_wd
);

    logic [4:0] w_byte_shift;
    logic [4:0] w_half_shift;

    // Halfword lane ignores addr[0] so an unaligned SH still lands on an aligned lane.
    assign w_byte_shift = {i_addr_q, 3'b000};
    assign w_half_shift = {i_addr_q[1], 4'b0000};

    // Replace the addressed lane of the read word; word stores bypass the merge.
    always_comb begin
        o_mem_wd = i_rd_q;
        case (i_size_q)
            SZ_SB:   o_mem_wd[w_byte_shift +: BYTE_W] = i_wdata_q[BYTE_W-1:0];
            SZ_SH:   o_mem_wd[w_half_shift +: HALF_W] = i_wdata_q[HALF_W-1:0];
            default: o_mem_wd = i_wdata_q;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// store_unit: sb/sh/sw into a word-wide memory without byte enables, using
// read-modify-write for sub-word stores. Optional macro STORE_MISALIGN_ERR_EN adds a misaligned-store trap.
module store_unit
    import store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    store_unit_if.slave bus
);

    store_state_e    r_state;
    store_size_e     r_size;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rd;
    logic            r_busy;
    logic            r_done;
    logic            r_we;
    store_size_e     w_req_size;
    logic [XLEN-1:0] w_mem_wd;

    assign w_req_size = norm_size(bus.size);

`ifdef STORE_MISALIGN_ERR_EN
    logic r_err;
    logic w_req_misaligned;
    assign w_req_misaligned = is_misaligned(w_req_size, bus.addr[1:0]);
`endif

    // Control FSM; busy/done/err/we are registered next to the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_size  <= SZ_SB;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rd    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
`ifdef STORE_MISALIGN_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b0;
`ifdef STORE_MISALIGN_ERR_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_addr  <= bus.addr;
                        r_size  <= w_req_size;
                        r_wdata <= bus.wdata;
                        r_busy  <= 1'b1;
`ifdef STORE_MISALIGN_ERR_EN
                        if (w_req_misaligned) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end else
`endif
                        if (w_req_size == SZ_SW) begin
                            r_state <= ST_WRITE;
                            r_done  <= 1'b1;
                            r_we    <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_READ: begin
                    r_rd    <= bus.mem_rd;
                    r_state <= ST_WRITE;
                    r_done  <= 1'b1;
                    r_we    <= 1'b1;
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
`ifdef STORE_MISALIGN_ERR_EN
                ST_ERR: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    store_merge u_merge (
        .i_rd_q    (r_rd),
        .i_wdata_q (r_wdata),
        .i_size_q  (r_size),
        .i_addr_q  (r_addr[1:0]),
        .o_mem_wd  (w_mem_wd)
    );

    // Reset gates the write combinationally so a store caught in WRITE never lands.
    assign bus.mem_we   = r_we & ~rst;
    assign bus.mem_wd   = w_mem_wd;
    assign bus.mem_addr = {r_addr[XLEN-1:2], 2'b00};
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
`ifdef STORE_MISALIGN_ERR_EN
    assign bus.err      = r_err;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed cases plus random stores against
// a byte-level memory model; honours STORE_MISALIGN_ERR_EN when defined.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic        poke_en;
    int          poke_idx;
    logic [31:0] poke_val;

    store_unit_if bus ();

    store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rd = mem[bus.mem_addr[5:2]];

    // Word-wide data memory; bench pokes share the port when the DUT is not writing.
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1)
            mem[bus.mem_addr[5:2]] <= bus.mem_wd;
        else if (poke_en)
            mem[poke_idx] <= poke_val;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        ref_mem[idx] = val;
        @(posedge clk);
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef STORE_MISALIGN_ERR_EN
        if (sz == 2'd1) return (a % 32'd2) != 32'd0;
        if (sz >= 2'd2) return (a % 32'd4) != 32'd0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int w;
        int off;
        int nbytes;
        int first;
        w      = int'(a / 32'd4) % 16;
        off    = int'(a % 32'd4);
        nbytes = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
        first  = (off / nbytes) * nbytes;
        for (int b = 0; b < nbytes; b++)
            ref_mem[w][8*(first+b) +: 8] = d[8*b +: 8];
    endfunction

    // Issue one store at a falling edge and watch it until busy drops.
    task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int cyc;
        int done_at;
        int err_at;
        int writes;
        int addr_bad;
        bit exp_err;
        int exp_busy;
        exp_err  = model_misaligned(sz, a);
        exp_busy = (exp_err || sz >= 2'd2) ? 1 : 2;
        check("idle_before_req", 32'(bus.busy), 32'd0);
        bus.req   = 1'b1;
        bus.size  = sz;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.req   = 1'b0;
        bus.size  = 2'($urandom_range(0, 3));
        bus.addr  = $urandom;
        bus.wdata = $urandom;
        cyc = 0; done_at = 0; err_at = 0; writes = 0; addr_bad = 0;
        while (bus.busy === 1'b1 && cyc < 8) begin
            cyc++;
            if (bus.done === 1'b1) done_at = cyc;
            if (bus.err === 1'b1) err_at = cyc;
            if (bus.mem_we === 1'b1) writes++;
            if (bus.mem_addr !== {a[31:2], 2'b00}) addr_bad++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(cyc), 32'(exp_busy));
        check("done_cycle", 32'(done_at), exp_err ? 32'd0 : 32'(exp_busy));
        check("err_cycle", 32'(err_at), exp_err ? 32'd1 : 32'd0);
        check("write_count", 32'(writes), exp_err ? 32'd0 : 32'd1);
        check("mem_addr_aligned", 32'(addr_bad), 32'd0);
        if (!exp_err) model_store(sz, a, d);
        check("mem_word", mem[a[5:2]], ref_mem[a[5:2]]);
    endtask

    initial begin
        bus.req   = 1'b0;
        bus.size  = 2'd0;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
        poke_en   = 1'b0;
        poke_idx  = 0;
        poke_val  = 32'd0;
        rst       = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) poke(i, $urandom);

        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        poke(2, 32'hdeadbeef);
        run_store(2'd0, 32'd9, 32'h000000a5);
        check("sb_addr9", mem[2], 32'hdeada5ef);

        poke(2, 32'hdeadbeef);
        run_store(2'd1, 32'd10, 32'h00001234);
        check("sh_addr10", mem[2], 32'h1234beef);

        poke(2, 32'hdeadbeef);
        run_store(2'd1, 32'd8, 32'h00001234);
        check("sh_addr8", mem[2], 32'hdead1234);

        run_store(2'd2, 32'd12, 32'hc001c0de);
        check("sw_addr12", mem[3], 32'hc001c0de);

        poke(2, 32'hdeadbeef);
        run_store(2'd1, 32'd9, 32'h00001234);
`ifdef STORE_MISALIGN_ERR_EN
        check("sh_addr9_trap", mem[2], 32'hdeadbeef);
`else
        check("sh_addr9_lane", mem[2], 32'hdead1234);
`endif

        run_store(2'd3, 32'd20, 32'h0badf00d);
        check("size3_as_sw", mem[5], 32'h0badf00d);

        // Reset while the read is in flight.
        poke(4, 32'h55aa33cc);
        bus.req = 1'b1; bus.size = 2'd0; bus.addr = 32'd17; bus.wdata = 32'h000000ff;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        check("rst_read_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_read_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_read_idle", 32'(bus.busy), 32'd0);
        check("rst_read_we2", 32'(bus.mem_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_read_word", mem[4], 32'h55aa33cc);

        // Reset arriving in the write cycle must suppress the write.
        bus.req = 1'b1; bus.size = 2'd0; bus.addr = 32'd18; bus.wdata = 32'h00000011;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_write_pending_we", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_write_gated_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_write_idle", 32'(bus.busy), 32'd0);
        check("rst_write_word", mem[4], 32'h55aa33cc);
        @(negedge clk);

        // Second request held high through the first store.
        poke(6, 32'h00000000);
        bus.req = 1'b1; bus.size = 2'd1; bus.addr = 32'd26; bus.wdata = 32'h0000abcd;
        @(posedge clk);
        @(negedge clk);
        check("b2b_first_read", 32'(bus.busy), 32'd1);
        bus.size = 2'd0; bus.addr = 32'd27; bus.wdata = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        check("b2b_first_done", 32'(bus.done), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_gap_idle", 32'(bus.busy), 32'd0);
        check("b2b_first_word", mem[6], 32'habcd0000);
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        check("b2b_second_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_second_done", 32'(bus.done), 32'd1);
        @(posedge clk);
        @(negedge clk);
        model_store(2'd1, 32'd26, 32'h0000abcd);
        model_store(2'd0, 32'd27, 32'h00000077);
        check("b2b_final_word", mem[6], 32'h77cd0000);
        check("b2b_model_word", mem[6], ref_mem[6]);

        for (int n = 0; n < 40; n++)
            run_store(2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)), $urandom);

        for (int i = 0; i < 16; i++)
            check("final_sweep", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
